// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the serial add/subtract controller
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/serial_adder_controller_fa.sv
// serial_full_adder: one-bit adder with registered carry and combinational sum
module serial_full_adder (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic init_val,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c,
  output logic c_next
);
  assign s = a ^ b ^ c;
  assign c_next = (a & b) | (a & c) | (b & c);
  always_ff @(posedge clk or posedge rst)
    if (rst) c <= 1'b0;
    else if (init) c <= init_val;
    else if (en) c <= c_next;
endmodule

// File: rtl/serial_adder_controller.sv
// serial_adder_controller: sequences two operand shift registers and adds/subtracts their bits LSB-first
module serial_adder_controller
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             a_sout,
  input  logic             b_sout,
  output logic             sr_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state;
  logic [CW-1:0] count;
  logic sub_l, s, c, c_next;
  serial_full_adder u_fa (
    .clk(clk), .rst(rst),
    .init(state == LOAD), .init_val(sub_l),
    .en(state == SHIFT),
    .a(a_sout), .b(b_sout ^ sub_l),
    .s(s), .c(c), .c_next(c_next)
  );
  // sum is the result shift register itself, so it holds until the next SHIFT edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      sub_l <= 1'b0;
      sr_mode <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= start ? LOAD : IDLE;
          busy <= start;
          if (start) sub_l <= sub;
        end
        LOAD: begin
          state <= SHIFT;
          count <= '0;
          sr_mode <= 1'b1;
        end
        SHIFT: begin
          sum <= {s, sum[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= DONE;
            sr_mode <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            cout <= c_next;
            ovf <= c ^ c_next;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/serial_adder_controller.md
# serial_adder_controller

Sequencing FSM for the serial add/subtract datapath built from two `input_shift_register` instances (operand A, operand B). It drives the shared `mode` line of both registers. It consumes their `sout` bits LSB-first, computes sum/difference one bit per clock with an internal carry flip-flop, and assembles the result in an internal output register. It reports the result through a start/busy/done handshake to the lab top level.

## Interface
- WIDTH, 8, operand/result width; bit counter is $clog2(WIDTH)+1 bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE or DONE
- sub  input  1  0 = A+B, 1 = A−B; sampled with start, held internally for the operation
- a_sout  input  1  serial bit from operand-A shift register
- b_sout  input  1  serial bit from operand-B shift register
- sr_mode  output  1  to both shift registers' `mode`: 0 = parallel load, 1 = shift right
- busy  output  1  high in LOAD and SHIFT
- done  output  1  one-cycle pulse on entry to DONE
- sum  output  WIDTH  result, valid from the done pulse until the next accepted start
- cout  output  1  final carry (add: carry out; sub: 1 = no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: sr_mode=0, so the registers continuously reload p_in. start=1 → LOAD; latch sub.
- LOAD: sr_mode=0 for exactly one cycle, which guarantees the load edge. Carry ← sub. Count ← 0. → SHIFT.
- SHIFT: sr_mode=1.
  - Each edge: b' = b_sout XOR sub_l; s = a_sout ^ b' ^ c; c ← majority(a_sout, b', c); result ← {s, result[WIDTH-1:1]}; count++.
  - On the WIDTH-th shift edge: capture ovf = c_in_msb ^ c_out → DONE.
- DONE: done=1 for this cycle only. sum/cout/ovf hold. sr_mode=0. start=1 → LOAD (back-to-back allowed); else → IDLE.
- IDLE after DONE keeps sum/cout/ovf stable. They change only when the next operation's SHIFT edges begin.
- start while busy is ignored; no queueing. sub changes while busy are ignored.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (async, any state, including mid-SHIFT): state=IDLE, sr_mode=0, busy=0, done=0, sum=0, cout=0, ovf=0, carry=0, count=0. Resumes on the first edge after rst deasserts.
- Latency: start sampled at edge 1 → LOAD; edge 2 loads the registers → SHIFT; edges 3..WIDTH+2 shift; done is high after edge WIDTH+2 (edge 10 for WIDTH=8) for one cycle.
- Throughput: one operation per WIDTH+2 cycles with start held high.
- a_sout/b_sout are sampled on the same edge that shifts the registers. The registers present bit k on sout during SHIFT cycle k.
- Operands on p_in must be stable from the start edge through the LOAD edge.

## Structure
- Package `serial_adder_pkg`: state enum (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3), default WIDTH localparam.
- Sub-module `serial_full_adder`: registered carry, combinational sum. It has a synchronous init input (carry ← init value), used in LOAD.
- Controller top: FSM, bit counter, result shift register, ovf capture.

## Test plan
- Add 0x92 + 0x35, sub=0: done after edge 10; sum=0xC7, cout=0, ovf=0; busy high for exactly 9 cycles.
- Add 0xFF + 0x01: sum=0x00, cout=1, ovf=0.
- Add 0x7F + 0x01: sum=0x80, cout=0, ovf=1.
- Sub 0x10 − 0x01: sum=0x0F, cout=1. Sub 0x01 − 0x02: sum=0xFF, cout=0.
- Start pulsed again in mid-SHIFT: ignored, result unchanged. Start held high: second done exactly 10 cycles after the first.
- rst asserted at SHIFT cycle 4: all outputs are 0 immediately, without waiting for a clock edge. Next start gives a correct full result.
